ft600_bus_scheduler: RTL and testbench
======================================

Name: ft600_bus_scheduler

Overview:
Half-duplex direction scheduler for the FT600 245-mode bus. It decides whether the PHY (send/receive datapath) may read host data (RX) or write FPGA data (TX). It enforces fair alternation with a burst limit and inserts a bus turnaround gap on every direction change. It sits between the FT600 PHY, the RX sink FIFO and the TX source FIFO, in the ftdi_clk domain.

Parameters:
MAX_BURST, 256, max words in one grant window before yielding to a pending opposite direction (>=1)
TURN_CYCLES, 2, idle cycles with both grants low on a direction change (>=1)
CNT_W, 12, width of FIFO level inputs
RX_MIN_SPACE, 4, minimum free RX-sink words needed to start an RX grant

Ports:
ftdi_clk  in  1  FT600 clock; the only clock in the block
rst  in  1  synchronous, active-high reset
sched_en  in  1  scheduler enable; 0 = no new grants, active grant withdrawn
ftdi_rxf_n  in  1  FT600 RXF_N; 0 = host data available
ftdi_txe_n  in  1  FT600 TXE_N; 0 = chip can accept data
rx_space_avail  in  CNT_W  free words in RX sink FIFO
tx_words_avail  in  CNT_W  words waiting in TX source FIFO
rx_word_strobe  in  1  PHY pulse, one per word read
tx_word_strobe  in  1  PHY pulse, one per word written
rx_grant  out  1  PHY may run the read sequence
tx_grant  out  1  PHY may drive the bus and write
bus_idle  out  1  both grants low, state IDLE
sched_state  out  2  0 IDLE, 1 TURNAROUND, 2 RX_ACTIVE, 3 TX_ACTIVE
burst_count  out  9  words moved in the current grant window (saturating width clog2(MAX_BURST)+1)
rx_word_total  out  32  cumulative RX words, wraps
tx_word_total  out  32  cumulative TX words, wraps
protocol_err  out  1  sticky: a strobe arrived without the matching grant

Behaviour:
- Reset (synchronous, rst=1 at a rising ftdi_clk edge) sets: state IDLE, rx_grant=0, tx_grant=0, bus_idle=1, burst_count=0, totals=0, protocol_err=0, last_dir=RX, pending_dir=RX, turn counter=0. If reset arrives mid-burst, both grants are low on the next cycle.
- Eligibility, combinational:
  - rx_elig = sched_en & ~ftdi_rxf_n & (rx_space_avail >= RX_MIN_SPACE)
  - tx_elig = sched_en & ~ftdi_txe_n & (tx_words_avail != 0)
- IDLE:
  - Neither eligible: stay in IDLE.
  - Exactly one eligible: choose that direction.
  - Both eligible: choose the direction opposite last_dir (round robin).
  - Chosen direction equals last_dir: next state is RX_ACTIVE or TX_ACTIVE.
  - Otherwise: store pending_dir, load turn counter with TURN_CYCLES, go to TURNAROUND.
- TURNAROUND:
  - Both grants are low. The counter decrements each cycle.
  - When the counter reaches 1, go to pending_dir ACTIVE on the next edge, even if that direction is no longer eligible. ACTIVE then exits after 1 cycle via its normal exit rule.
- Grants are decoded directly from the state register: rx_grant = (state==RX_ACTIVE), tx_grant = (state==TX_ACTIVE). They are never high together.
- Latency, with eligibility sampled at edge N:
  - Same direction: grant high from cycle N+1.
  - Direction change: grant high from cycle N+1+TURN_CYCLES.
- RX_ACTIVE:
  - Each rx_word_strobe increments burst_count and rx_word_total.
  - Exit to IDLE on the next edge if any of: ftdi_rxf_n=1, rx_space_avail==0, sched_en=0, or (burst_count==MAX_BURST and tx_elig).
  - On exit: last_dir=RX, burst_count=0.
  - burst_count==MAX_BURST with tx not eligible: burst_count restarts at 0 (a strobe in the same cycle gives 1) and the grant continues.
- TX_ACTIVE: mirror of RX_ACTIVE.
  - Counting uses tx_word_strobe.
  - Exit conditions: ftdi_txe_n=1, tx_words_avail==0, sched_en=0, or (burst_count==MAX_BURST and rx_elig).
  - On exit: last_dir=TX.
- A strobe in the exit cycle is still counted.
- A strobe whose grant is low sets protocol_err (cleared only by rst) and is not counted. A strobe while the matching grant is high is always legal.
- Both strobes in the same cycle: the granted one counts, the other sets protocol_err.
- Totals wrap from 0xFFFFFFFF to 0.
- bus_idle = (state==IDLE).

Test Plan:
- Reset, then rxf_n=0, rx_space=100, tx idle: IDLE, then TURN not required (last_dir=RX). rx_grant=1 the cycle after eligibility. 10 rx strobes give rx_word_total=10. rxf_n goes to 1: rx_grant=0 next cycle, burst_count=0.
- Both directions eligible from reset: TX chosen (opposite RX), 2 cycles of TURNAROUND with both grants 0, then tx_grant=1. Strobe every cycle: after 256 words tx_grant drops, 2 idle turnaround cycles follow, then rx_grant=1.
- RX only, MAX_BURST=256, 600 continuous strobes: rx_grant stays high throughout, burst_count wraps 256 to 1, rx_word_total=600.
- TX active, tx_words_avail drops to 0 mid-burst: tx_grant=0 next cycle. A tx strobe one cycle later sets protocol_err=1, and tx_word_total is unchanged.
- rx_space_avail=3 (below RX_MIN_SPACE=4) with rxf_n=0: no grant. Raise to 4: rx_grant=1 next cycle.
- Assert rst during TX_ACTIVE with burst_count=50: next cycle tx_grant=0, state=0, totals=0, protocol_err=0. sched_en=0 keeps bus_idle=1 with all requests asserted.

Source files
------------

// File: rtl/ft600_bus_scheduler.sv
// ft600_bus_scheduler
// Half-duplex direction scheduler for the FT600 245-mode bus. Grants the PHY
// either the read (RX) or write (TX) direction. It alternates fairly between
// the two directions, limits a burst when the other side is waiting, and
// inserts a turnaround gap with both grants low on every direction change.
// Everything runs on ftdi_clk, and reset is synchronous and active-high.

module ft600_bus_scheduler #(
  parameter int MAX_BURST    = 256,
  parameter int TURN_CYCLES  = 2,
  parameter int CNT_W        = 12,
  parameter int RX_MIN_SPACE = 4
) (
  input  logic                        ftdi_clk,
  input  logic                        rst,
  input  logic                        sched_en,
  input  logic                        ftdi_rxf_n,
  input  logic                        ftdi_txe_n,
  input  logic [CNT_W-1:0]            rx_space_avail,
  input  logic [CNT_W-1:0]            tx_words_avail,
  input  logic                        rx_word_strobe,
  input  logic                        tx_word_strobe,
  output logic                        rx_grant,
  output logic                        tx_grant,
  output logic                        bus_idle,
  output logic [1:0]                  sched_state,
  output logic [$clog2(MAX_BURST):0]  burst_count,
  output logic [31:0]                 rx_word_total,
  output logic [31:0]                 tx_word_total,
  output logic                        protocol_err
);

  // Burst counter must be able to hold MAX_BURST itself, hence the extra bit.
  localparam int BC_W = $clog2(MAX_BURST) + 1;
  // Turn counter holds values 0..TURN_CYCLES.
  localparam int TC_W = (TURN_CYCLES < 2) ? 1 : $clog2(TURN_CYCLES + 1);

  localparam logic [BC_W-1:0]  BURST_MAX_L = BC_W'(MAX_BURST);
  localparam logic [TC_W-1:0]  TURN_LOAD_L = TC_W'(TURN_CYCLES);
  localparam logic [TC_W-1:0]  TURN_ONE_L  = TC_W'(1);
  localparam logic [CNT_W-1:0] RX_MIN_L    = CNT_W'(RX_MIN_SPACE);
  localparam logic [CNT_W-1:0] CNT_ZERO_L  = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_RX   = 2'd2,
    ST_TX   = 2'd3
  } state_t;

  // Direction encoding for last_dir / pending_dir.
  localparam logic DIR_RX = 1'b0;
  localparam logic DIR_TX = 1'b1;

  state_t            r_state;
  logic              r_last_dir;
  logic              r_pending_dir;
  logic [TC_W-1:0]   r_turn_cnt;
  logic [BC_W-1:0]   r_burst_cnt;
  logic [31:0]       r_rx_total;
  logic [31:0]       r_tx_total;
  logic              r_protocol_err;

  logic w_rx_elig;
  logic w_tx_elig;
  logic w_any_elig;
  logic w_pick_dir;
  logic w_burst_full;
  logic w_rx_exit;
  logic w_tx_exit;
  logic w_rx_count;
  logic w_tx_count;
  logic w_strobe_err;

  // A direction is eligible only when enabled, the chip is ready, and the
  // FIFO on our side can take or supply data.
  assign w_rx_elig  = sched_en & ~ftdi_rxf_n & (rx_space_avail >= RX_MIN_L);
  assign w_tx_elig  = sched_en & ~ftdi_txe_n & (tx_words_avail != CNT_ZERO_L);
  assign w_any_elig = w_rx_elig | w_tx_elig;

  // A single candidate wins outright. With both candidates, round robin
  // against the last direction served.
  assign w_pick_dir = (w_rx_elig & w_tx_elig) ? ~r_last_dir : w_tx_elig;

  assign w_burst_full = (r_burst_cnt == BURST_MAX_L);

  // A grant ends when its own side stalls, the scheduler is disabled, or a
  // full burst has run while the opposite side is waiting.
  assign w_rx_exit = ftdi_rxf_n | (rx_space_avail == CNT_ZERO_L) | ~sched_en |
                     (w_burst_full & w_tx_elig);
  assign w_tx_exit = ftdi_txe_n | (tx_words_avail == CNT_ZERO_L) | ~sched_en |
                     (w_burst_full & w_rx_elig);

  // A strobe counts only while its own grant is high. Any other strobe is a
  // PHY protocol violation.
  assign w_rx_count   = rx_word_strobe & (r_state == ST_RX);
  assign w_tx_count   = tx_word_strobe & (r_state == ST_TX);
  assign w_strobe_err = (rx_word_strobe & (r_state != ST_RX)) |
                        (tx_word_strobe & (r_state != ST_TX));

  // Direction FSM with turnaround timer and per-window burst counter.
  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_last_dir    <= DIR_RX;
      r_pending_dir <= DIR_RX;
      r_turn_cnt    <= '0;
      r_burst_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_burst_cnt <= '0;
          if (w_any_elig) begin
            if (w_pick_dir == r_last_dir) begin
              r_state <= (w_pick_dir == DIR_TX) ? ST_TX : ST_RX;
            end else begin
              r_pending_dir <= w_pick_dir;
              r_turn_cnt    <= TURN_LOAD_L;
              r_state       <= ST_TURN;
            end
          end
        end

        ST_TURN: begin
          // Commit to the pending direction even if it lost eligibility.
          // The active state then drops it after one cycle.
          if (r_turn_cnt <= TURN_ONE_L) begin
            r_turn_cnt <= '0;
            r_state    <= (r_pending_dir == DIR_TX) ? ST_TX : ST_RX;
          end else begin
            r_turn_cnt <= r_turn_cnt - TURN_ONE_L;
          end
        end

        ST_RX: begin
          if (w_rx_exit) begin
            r_state     <= ST_IDLE;
            r_last_dir  <= DIR_RX;
            r_burst_cnt <= '0;
          end else if (w_burst_full) begin
            // Nobody waiting on the other side: open a fresh window in place.
            r_burst_cnt <= BC_W'(rx_word_strobe);
          end else begin
            r_burst_cnt <= r_burst_cnt + BC_W'(rx_word_strobe);
          end
        end

        ST_TX: begin
          if (w_tx_exit) begin
            r_state     <= ST_IDLE;
            r_last_dir  <= DIR_TX;
            r_burst_cnt <= '0;
          end else if (w_burst_full) begin
            r_burst_cnt <= BC_W'(tx_word_strobe);
          end else begin
            r_burst_cnt <= r_burst_cnt + BC_W'(tx_word_strobe);
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Cumulative word totals. These wrap naturally at 32 bits, and a strobe in
  // the exit cycle is still counted.
  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      r_rx_total <= '0;
      r_tx_total <= '0;
    end else begin
      if (w_rx_count) r_rx_total <= r_rx_total + 32'd1;
      if (w_tx_count) r_tx_total <= r_tx_total + 32'd1;
    end
  end

  // Sticky protocol error flag, cleared only by reset.
  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      r_protocol_err <= 1'b0;
    end else if (w_strobe_err) begin
      r_protocol_err <= 1'b1;
    end
  end

  // Grants are pure decodes of the state register, so they can never be
  // high at the same time.
  assign rx_grant      = (r_state == ST_RX);
  assign tx_grant      = (r_state == ST_TX);
  assign bus_idle      = (r_state == ST_IDLE);
  assign sched_state   = r_state;
  assign burst_count   = r_burst_cnt;
  assign rx_word_total = r_rx_total;
  assign tx_word_total = r_tx_total;
  assign protocol_err  = r_protocol_err;

endmodule

// File: tb/tb_ft600_bus_scheduler.sv
// Directed testbench for ft600_bus_scheduler with default parameters
// (MAX_BURST=256, TURN_CYCLES=2, RX_MIN_SPACE=4). Inputs are driven 1 ns
// after each rising edge, and outputs are checked at that same point.

module tb_ft600_bus_scheduler;

  logic        ftdi_clk = 1'b0;
  logic        rst;
  logic        sched_en;
  logic        ftdi_rxf_n;
  logic        ftdi_txe_n;
  logic [11:0] rx_space_avail;
  logic [11:0] tx_words_avail;
  logic        rx_word_strobe;
  logic        tx_word_strobe;
  logic        rx_grant;
  logic        tx_grant;
  logic        bus_idle;
  logic [1:0]  sched_state;
  logic [8:0]  burst_count;
  logic [31:0] rx_word_total;
  logic [31:0] tx_word_total;
  logic        protocol_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 ftdi_clk = ~ftdi_clk;

  ft600_bus_scheduler dut (
    .ftdi_clk       (ftdi_clk),
    .rst            (rst),
    .sched_en       (sched_en),
    .ftdi_rxf_n     (ftdi_rxf_n),
    .ftdi_txe_n     (ftdi_txe_n),
    .rx_space_avail (rx_space_avail),
    .tx_words_avail (tx_words_avail),
    .rx_word_strobe (rx_word_strobe),
    .tx_word_strobe (tx_word_strobe),
    .rx_grant       (rx_grant),
    .tx_grant       (tx_grant),
    .bus_idle       (bus_idle),
    .sched_state    (sched_state),
    .burst_count    (burst_count),
    .rx_word_total  (rx_word_total),
    .tx_word_total  (tx_word_total),
    .protocol_err   (protocol_err)
  );

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Advance one clock and settle 1 ns past the edge.
  task automatic tick();
    @(posedge ftdi_clk);
    #1;
  endtask

  int drop_cnt;
  int err_cnt;

  initial begin
    rst = 1'b1; sched_en = 1'b0; ftdi_rxf_n = 1'b1; ftdi_txe_n = 1'b1;
    rx_space_avail = '0; tx_words_avail = '0;
    rx_word_strobe = 1'b0; tx_word_strobe = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_state", 32'(sched_state), 0);
    chk("rst_rx_grant", 32'(rx_grant), 0);
    chk("rst_tx_grant", 32'(tx_grant), 0);
    chk("rst_bus_idle", 32'(bus_idle), 1);
    chk("rst_burst", 32'(burst_count), 0);
    chk("rst_rx_total", rx_word_total, 0);
    chk("rst_tx_total", tx_word_total, 0);
    chk("rst_perr", 32'(protocol_err), 0);

    // RX only: same direction as last_dir, so no turnaround
    rst = 1'b0; sched_en = 1'b1; ftdi_rxf_n = 1'b0; rx_space_avail = 12'd100;
    tick();
    chk("rx1_grant", 32'(rx_grant), 1);
    chk("rx1_state", 32'(sched_state), 2);
    rx_word_strobe = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    rx_word_strobe = 1'b0;
    chk("rx1_total10", rx_word_total, 10);
    chk("rx1_burst10", 32'(burst_count), 10);
    ftdi_rxf_n = 1'b1;
    tick();
    chk("rx1_exit_grant", 32'(rx_grant), 0);
    chk("rx1_exit_burst", 32'(burst_count), 0);
    chk("rx1_exit_idle", 32'(bus_idle), 1);

    // RX space below threshold blocks the grant. At threshold it is granted.
    ftdi_rxf_n = 1'b0; rx_space_avail = 12'd3;
    tick(); tick();
    chk("rxmin3_grant", 32'(rx_grant), 0);
    chk("rxmin3_state", 32'(sched_state), 0);
    rx_space_avail = 12'd4;
    tick();
    chk("rxmin4_grant", 32'(rx_grant), 1);
    ftdi_rxf_n = 1'b1;
    tick();
    chk("rxmin_exit", 32'(rx_grant), 0);

    // Both eligible from reset: TX chosen, two turnaround cycles
    rst = 1'b1;
    tick();
    rst = 1'b0; ftdi_rxf_n = 1'b0; rx_space_avail = 12'd100;
    ftdi_txe_n = 1'b0; tx_words_avail = 12'd500;
    tick();
    chk("both_turn1_state", 32'(sched_state), 1);
    chk("both_turn1_grants", 32'({rx_grant, tx_grant}), 0);
    tick();
    chk("both_turn2_state", 32'(sched_state), 1);
    chk("both_turn2_grants", 32'({rx_grant, tx_grant}), 0);
    tick();
    chk("both_tx_grant", 32'(tx_grant), 1);
    chk("both_tx_rxg", 32'(rx_grant), 0);
    tx_word_strobe = 1'b1;
    for (int i = 0; i < 256; i++) tick();
    tx_word_strobe = 1'b0;
    chk("both_burst256", 32'(burst_count), 256);
    chk("both_tx_total256", tx_word_total, 256);
    chk("both_still_tx", 32'(tx_grant), 1);
    tick();
    chk("both_yield_txg", 32'(tx_grant), 0);
    chk("both_yield_state", 32'(sched_state), 0);
    chk("both_yield_burst", 32'(burst_count), 0);
    tick();
    chk("both_rturn1", 32'(sched_state), 1);
    tick();
    chk("both_rturn2", 32'(sched_state), 1);
    tick();
    chk("both_rx_grant", 32'(rx_grant), 1);

    // RX only, 600 continuous strobes, with the burst counter wrapping 256 -> 1
    rst = 1'b1; ftdi_txe_n = 1'b1; tx_words_avail = '0;
    tick();
    rst = 1'b0;
    tick();
    chk("long_rx_grant", 32'(rx_grant), 1);
    rx_word_strobe = 1'b1;
    drop_cnt = 0;
    for (int i = 1; i <= 600; i++) begin
      tick();
      if (rx_grant !== 1'b1) drop_cnt++;
      if (i == 256) chk("long_burst_at256", 32'(burst_count), 256);
      if (i == 257) chk("long_burst_at257", 32'(burst_count), 1);
    end
    rx_word_strobe = 1'b0;
    chk("long_grant_drops", 32'(drop_cnt), 0);
    chk("long_rx_total600", rx_word_total, 600);
    chk("long_burst_end", 32'(burst_count), 88);
    ftdi_rxf_n = 1'b1;
    tick();
    chk("long_exit", 32'(rx_grant), 0);

    // TX mid-burst starvation, then a stray strobe
    ftdi_txe_n = 1'b0; tx_words_avail = 12'd5;
    tick(); tick(); tick();
    chk("starve_tx_grant", 32'(tx_grant), 1);
    tx_word_strobe = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    tx_word_strobe = 1'b0; tx_words_avail = '0;
    chk("starve_total3", tx_word_total, 3);
    tick();
    chk("starve_txg_low", 32'(tx_grant), 0);
    chk("starve_perr0", 32'(protocol_err), 0);
    tx_word_strobe = 1'b1;
    tick();
    tx_word_strobe = 1'b0;
    chk("stray_perr", 32'(protocol_err), 1);
    chk("stray_total", tx_word_total, 3);
    tick();
    chk("stray_perr_sticky", 32'(protocol_err), 1);

    // Reset during TX_ACTIVE with burst_count=50
    tx_words_avail = 12'd100;
    tick();
    chk("rstmid_tx_grant", 32'(tx_grant), 1);
    tx_word_strobe = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    tx_word_strobe = 1'b0;
    chk("rstmid_burst50", 32'(burst_count), 50);
    rst = 1'b1;
    tick();
    chk("rstmid_txg", 32'(tx_grant), 0);
    chk("rstmid_state", 32'(sched_state), 0);
    chk("rstmid_rx_total", rx_word_total, 0);
    chk("rstmid_tx_total", tx_word_total, 0);
    chk("rstmid_perr", 32'(protocol_err), 0);
    chk("rstmid_burst", 32'(burst_count), 0);

    // sched_en=0 holds the bus idle with every request asserted
    rst = 1'b0; sched_en = 1'b0; ftdi_rxf_n = 1'b0; ftdi_txe_n = 1'b0;
    rx_space_avail = 12'd100; tx_words_avail = 12'd100;
    err_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus_idle !== 1'b1 || rx_grant !== 1'b0 || tx_grant !== 1'b0) err_cnt++;
    end
    chk("dis_not_idle_cycles", 32'(err_cnt), 0);

    // Both strobes together: the granted RX counts, and TX flags an error
    sched_en = 1'b1; ftdi_txe_n = 1'b1;
    tick();
    chk("dual_rx_grant", 32'(rx_grant), 1);
    rx_word_strobe = 1'b1; tx_word_strobe = 1'b1;
    tick();
    rx_word_strobe = 1'b0; tx_word_strobe = 1'b0;
    chk("dual_rx_total", rx_word_total, 1);
    chk("dual_tx_total", tx_word_total, 0);
    chk("dual_perr", 32'(protocol_err), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
